// File: rtl/streaming_majority.sv
// Streaming per-bit majority voter over the last DEPTH 8-bit samples, sliding or batch mode.
// Define STREAMING_MAJORITY_FILL_EN to expose the fill count on uio_out[7:4].
module streaming_majority #(
   parameter int DEPTH = 5
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] ui_in,
   input  logic [7:0] uio_in,
   output logic [7:0] uo_out,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int HALF = (DEPTH + 1) / 2;
   localparam logic [3:0] FULL = 4'(DEPTH);

   generate
      if (DEPTH < 3 || DEPTH > 15 || (DEPTH % 2) == 0) begin : g_bad_depth
         $error("streaming_majority: DEPTH must be odd and within 3..15");
      end
   endgenerate

   logic [7:0]    hist [DEPTH];
   logic [CW-1:0] cnt [8];
   logic [CW:0]   sum_w [8];
   logic [3:0]    fill;
   logic [3:0]    fill_nxt;
   logic          mode;
   logic          valid;
   logic [7:0]    maj;

   logic strobe;
   logic mode_in;
   logic clear;
   logic restart;
   logic full;

   assign strobe  = uio_in[0];
   assign mode_in = uio_in[1];
   assign clear   = uio_in[2];
   assign restart = clear | (mode_in != mode);
   assign full    = (fill == FULL);

   wire unused = &{1'b0, uio_in[7:3]};

   // Sum is one bit wider than the counters so the sliding add can briefly exceed DEPTH before the oldest bit leaves.
   always_comb begin
      fill_nxt = (full && !mode) ? fill : fill + 4'd1;
      maj      = '0;
      for (int i = 0; i < 8; i++) begin
         sum_w[i] = {1'b0, cnt[i]} + (CW+1)'(ui_in[i]);
         if (!mode && full) begin
            sum_w[i] = sum_w[i] - (CW+1)'(hist[DEPTH-1][i]);
         end
         maj[i] = (sum_w[i] >= (CW+1)'(HALF));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            hist[i] <= '0;
         end
      end else if (ena) begin
         if (restart) begin
            for (int i = 0; i < DEPTH; i++) begin
               hist[i] <= '0;
            end
         end else if (strobe && !mode) begin
            hist[0] <= ui_in;
            for (int i = 1; i < DEPTH; i++) begin
               hist[i] <= hist[i-1];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 8; i++) begin
            cnt[i] <= '0;
         end
         fill   <= '0;
         mode   <= 1'b0;
         uo_out <= '0;
         valid  <= 1'b0;
      end else if (ena) begin
         if (restart) begin
            for (int i = 0; i < 8; i++) begin
               cnt[i] <= '0;
            end
            fill   <= '0;
            mode   <= mode_in;
            uo_out <= '0;
            valid  <= 1'b0;
         end else if (strobe) begin
            if (!mode) begin
               for (int i = 0; i < 8; i++) begin
                  cnt[i] <= sum_w[i][CW-1:0];
               end
               fill <= fill_nxt;
               if (fill_nxt == FULL) begin
                  uo_out <= maj;
                  valid  <= 1'b1;
               end
            end else if (fill_nxt == FULL) begin
               // Batch completes: publish the result and start the next block from empty.
               for (int i = 0; i < 8; i++) begin
                  cnt[i] <= '0;
               end
               fill   <= '0;
               uo_out <= maj;
               valid  <= 1'b1;
            end else begin
               for (int i = 0; i < 8; i++) begin
                  cnt[i] <= sum_w[i][CW-1:0];
               end
               fill  <= fill_nxt;
               valid <= 1'b0;
            end
         end else if (mode) begin
            valid <= 1'b0;
         end
      end
   end

`ifdef STREAMING_MAJORITY_FILL_EN
   assign uio_out = {fill, valid, 3'b000};
   assign uio_oe  = 8'hF8;
`else
   assign uio_out = {4'b0000, valid, 3'b000};
   assign uio_oe  = 8'h08;
`endif

endmodule

// File: tb/tb_streaming_majority.sv
// Scoreboard bench for streaming_majority (DEPTH=3): queue-based window model, directed and random stimulus.
module tb_streaming_majority;

   localparam int DEPTH = 3;

   logic       clk;
   logic       rst_n;
   logic       ena;
   logic [7:0] ui_in;
   logic [7:0] uio_in;
   logic [7:0] uo_out;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;

   int checks = 0;
   int errors = 0;
   bit done = 0;

   logic [23:0] exp_q[$];
   logic [7:0]  win_q[$];
   logic        m_mode;
   logic [7:0]  m_uo;
   logic        m_valid;

`ifdef STREAMING_MAJORITY_FILL_EN
   localparam logic [7:0] EXP_OE = 8'hF8;
`else
   localparam logic [7:0] EXP_OE = 8'h08;
`endif

   streaming_majority #(.DEPTH(DEPTH)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .ena(ena),
      .ui_in(ui_in),
      .uio_in(uio_in),
      .uo_out(uo_out),
      .uio_out(uio_out),
      .uio_oe(uio_oe)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] windowMajority();
      logic [7:0] r;
      r = '0;
      for (int b = 0; b < 8; b++) begin
         int ones;
         ones = 0;
         foreach (win_q[k]) ones += int'(win_q[k][b]);
         r[b] = (2 * ones > win_q.size());
      end
      return r;
   endfunction

   task automatic modelReset();
      win_q.delete();
      m_mode  = 1'b0;
      m_uo    = '0;
      m_valid = 1'b0;
   endtask

   task automatic modelStep(input bit en, input bit stb, input logic [7:0] data, input bit md, input bit clr);
      if (!en) return;
      if (clr || md != m_mode) begin
         win_q.delete();
         m_uo    = '0;
         m_valid = 1'b0;
         m_mode  = md;
      end else if (stb) begin
         win_q.push_back(data);
         if (!m_mode) begin
            if (win_q.size() > DEPTH) void'(win_q.pop_front());
            if (win_q.size() == DEPTH) begin
               m_uo    = windowMajority();
               m_valid = 1'b1;
            end
         end else if (win_q.size() == DEPTH) begin
            m_uo    = windowMajority();
            m_valid = 1'b1;
            win_q.delete();
         end else begin
            m_valid = 1'b0;
         end
      end else if (m_mode) begin
         m_valid = 1'b0;
      end
   endtask

   function automatic logic [7:0] expectedUio();
      logic [3:0] f;
`ifdef STREAMING_MAJORITY_FILL_EN
      f = 4'(win_q.size());
`else
      f = 4'd0;
`endif
      return {f, m_valid, 3'b000};
   endfunction

   task automatic applyStimulus(input bit en, input bit stb, input logic [7:0] data,
                                input bit md, input bit clr, input logic [4:0] junk = 5'd0);
      ena    = en;
      ui_in  = data;
      uio_in = {junk, clr, md, stb};
      @(posedge clk);
      modelStep(en, stb, data, md, clr);
      exp_q.push_back({m_uo, expectedUio(), EXP_OE});
      #1;
   endtask

   // Monitor: compares the DUT against each expectation queued by the driver.
   initial begin
      logic [23:0] e;
      while (!done) begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checkOutput("sb_uo_out", uo_out, e[23:16]);
            checkOutput("sb_uio_out", uio_out, e[15:8]);
            checkOutput("sb_uio_oe", uio_oe, e[7:0]);
         end
      end
   end

   initial begin
      logic [7:0] held;
      bit md;
      rst_n  = 1'b0;
      ena    = 1'b0;
      ui_in  = '0;
      uio_in = '0;
      modelReset();
      #2;
      checkOutput("reset_uo_out", uo_out, 8'h00);
      checkOutput("reset_uio_out", uio_out, 8'h00);
      checkOutput("reset_uio_oe", uio_oe, EXP_OE);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Sliding fill-up and slide-out
      applyStimulus(1, 1, 8'hFF, 0, 0);
      checkOutput("slide1_valid", {7'd0, uio_out[3]}, 8'h00);
      applyStimulus(1, 1, 8'h00, 0, 0);
      checkOutput("slide2_valid", {7'd0, uio_out[3]}, 8'h00);
      applyStimulus(1, 1, 8'hFF, 0, 0);
      checkOutput("slide3_uo", uo_out, 8'hFF);
      checkOutput("slide3_valid", {7'd0, uio_out[3]}, 8'h01);
      applyStimulus(1, 1, 8'h00, 0, 0);
      checkOutput("slide4_uo", uo_out, 8'h00);

      // Per-bit independence
      applyStimulus(1, 0, 8'h00, 0, 1);
      checkOutput("clear_uo", uo_out, 8'h00);
      applyStimulus(1, 1, 8'hF0, 0, 0);
      applyStimulus(1, 1, 8'h3C, 0, 0);
      applyStimulus(1, 1, 8'h0F, 0, 0);
      checkOutput("perbit_uo", uo_out, 8'h3C);

      // Batch mode (entry cycle discards its strobe)
      applyStimulus(1, 1, 8'hAA, 1, 0);
      checkOutput("batch_entry_valid", {7'd0, uio_out[3]}, 8'h00);
      applyStimulus(1, 1, 8'hAA, 1, 0);
      applyStimulus(1, 1, 8'hAA, 1, 0);
      applyStimulus(1, 1, 8'h55, 1, 0);
      checkOutput("batch1_uo", uo_out, 8'hAA);
      checkOutput("batch1_valid", {7'd0, uio_out[3]}, 8'h01);
      applyStimulus(1, 0, 8'h00, 1, 0);
      checkOutput("batch_idle_valid", {7'd0, uio_out[3]}, 8'h00);
      checkOutput("batch_idle_uo", uo_out, 8'hAA);
      applyStimulus(1, 1, 8'h55, 1, 0);
      checkOutput("batch4_valid", {7'd0, uio_out[3]}, 8'h00);
      applyStimulus(1, 1, 8'h55, 1, 0);
      checkOutput("batch5_valid", {7'd0, uio_out[3]}, 8'h00);
      applyStimulus(1, 1, 8'hAA, 1, 0);
      checkOutput("batch2_uo", uo_out, 8'h55);
      checkOutput("batch2_valid", {7'd0, uio_out[3]}, 8'h01);

      // Clear together with a strobe after two sliding strobes
      applyStimulus(1, 1, 8'h11, 0, 0);
      applyStimulus(1, 1, 8'h11, 0, 0);
      applyStimulus(1, 1, 8'h11, 0, 0);
      applyStimulus(1, 1, 8'h11, 0, 1);
      checkOutput("clrstb_uo", uo_out, 8'h00);
      checkOutput("clrstb_uio", uio_out, 8'h00);
      applyStimulus(1, 1, 8'hFF, 0, 0);
      applyStimulus(1, 1, 8'hFF, 0, 0);
      checkOutput("clrstb_refill_valid", {7'd0, uio_out[3]}, 8'h00);
      applyStimulus(1, 1, 8'hFF, 0, 0);
      checkOutput("clrstb_full_uo", uo_out, 8'hFF);

      // Mode toggle after two strobes
      applyStimulus(1, 0, 8'h00, 0, 1);
      applyStimulus(1, 1, 8'hC3, 0, 0);
      applyStimulus(1, 1, 8'hC3, 0, 0);
      applyStimulus(1, 1, 8'hC3, 1, 0);
      checkOutput("toggle_uio", uio_out, 8'h00);
      applyStimulus(1, 1, 8'hC3, 0, 0);
      applyStimulus(1, 1, 8'hC3, 0, 0);
      applyStimulus(1, 1, 8'hC3, 0, 0);
      checkOutput("toggle_refill_valid", {7'd0, uio_out[3]}, 8'h00);
      applyStimulus(1, 1, 8'hC3, 0, 0);
      checkOutput("toggle_full_uo", uo_out, 8'hC3);

      // Disabled: strobes, clears and mode changes all ignored
      held = 8'hC3;
      for (int i = 0; i < 8; i++) begin
         applyStimulus(0, i[0], 8'($urandom), 1'($urandom), 1'($urandom));
      end
      checkOutput("ena_low_uo", uo_out, held);

      // Asynchronous reset mid-batch
      applyStimulus(1, 0, 8'h00, 1, 0);
      applyStimulus(1, 1, 8'h5A, 1, 0);
      applyStimulus(1, 1, 8'h5A, 1, 0);
      applyStimulus(1, 1, 8'h5A, 1, 0);
      applyStimulus(1, 1, 8'h0F, 1, 0);
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      checkOutput("async_rst_uo", uo_out, 8'h00);
      checkOutput("async_rst_uio", uio_out, 8'h00);
      modelReset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Randomized traffic
      md = 1'b0;
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 24) == 0) md = ~md;
         applyStimulus($urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0, 8'($urandom), md,
                       $urandom_range(0, 39) == 0, 5'($urandom));
      end

      @(negedge clk);
      #1;
      done = 1'b1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/streaming_majority.md
# streaming_majority

Sequential, parametrised successor to the combinational bitwise majority voter. It takes a stream of 8-bit samples on the dedicated inputs and computes a per-bit majority over the last DEPTH samples, not over three parallel operands. It supports a sliding-window mode and a batch (non-overlapping block) mode. It sits directly on the Tiny Tapeout pin interface as a user project top.

## Interface
- DEPTH, default 5: window length in samples. Must be odd, 3..15; any other value is an elaboration error.
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- ena  input  1  design enable. When low, strobes and clears are ignored and all state holds.
- ui_in  input  8  sample data, captured on a strobe.
- uio_in  input  8  control inputs:
  - [0] sample strobe
  - [1] mode (0 = sliding, 1 = batch)
  - [2] synchronous clear
  - [7:3] unused
- uo_out  output  8  registered majority result.
- uio_out  output  8  status:
  - [3] valid
  - [7:4] fill count (only with the macro below)
  - other bits 0
- uio_oe  output  8  constant: 8'h08, or 8'hF8 with the macro.

## Operation
- State:
  - history shift register, DEPTH x 8
  - eight per-bit ones-counters, width $clog2(DEPTH+1)
  - fill counter, 0..DEPTH
  - registered mode bit
  - uo_out and valid registers
- Majority bit i = (cnt_next[i] >= (DEPTH+1)/2). DEPTH is odd, so ties cannot occur.
- Priority per enabled cycle: clear > mode change > strobe.
- Clear (uio_in[2]=1) zeroes the history, counters, fill, uo_out and valid. A strobe in the same cycle is discarded.
- Mode change (uio_in[1] differs from the registered mode) acts as a clear and loads the new mode. A strobe in that cycle is discarded.
- Sliding mode, on each strobe:
  - shift ui_in into the history
  - cnt_next = cnt + new_bit − (fill==DEPTH ? oldest_bit : 0)
  - fill saturates at DEPTH
  - while fill_next < DEPTH: uo_out holds 0 and valid stays 0
  - when fill_next == DEPTH: uo_out loads the majority and valid is set
  - valid then stays 1 until a clear, a mode change or reset
- Batch mode, on each strobe:
  - cnt_next = cnt + new_bit; fill increments
  - on the strobe where fill_next == DEPTH: uo_out loads the majority and valid pulses high for exactly one cycle
  - on that same edge the counters and fill return to 0
  - uo_out holds the last batch result until the next batch completes
- No strobe: all state holds; batch-mode valid drops after its one-cycle pulse.

## Timing
- Reset values: uo_out=0x00, uio_out=0x00, valid=0, fill=0, counters=0, history=0, mode=0.
- Reset asserts asynchronously; outputs reach 0 without waiting for a clock.
- Latency: a strobe at edge N updates uo_out, valid and fill at edge N (registered). They are visible in the cycle after edge N.
- Back-to-back strobes every cycle are supported at full rate, with no stall.
- Reset mid-window or mid-batch discards all partial state.

## Configuration
- STREAMING_MAJORITY_FILL_EN:
  - when defined: uio_out[7:4] = fill (after the update, 0..DEPTH) and uio_oe = 8'hF8
  - when undefined: uio_out[7:4] = 0, uio_oe = 8'h08, and no fill output logic is instantiated
- Majority behaviour is identical in both builds.

## Test plan
- DEPTH=3, sliding: strobes 0xFF, 0x00, 0xFF.
  - valid=0 after the first two strobes; uo_out=0xFF and valid=1 after the third
  - fourth strobe 0x00 → uo_out=0x00
- DEPTH=3, sliding, per-bit independence: strobes 0xF0, 0x3C, 0x0F → uo_out=0x3C.
- DEPTH=3, batch: strobes 0xAA, 0xAA, 0x55, 0x55, 0x55, 0xAA.
  - uo_out=0xAA with a one-cycle valid pulse after strobe 3
  - uo_out=0x55 with a one-cycle valid pulse after strobe 6
  - valid=0 in between
- Clear and mode change:
  - after 2 sliding strobes, assert clear together with a strobe → fill=0, valid=0, uo_out=0x00; 3 further strobes are needed before valid returns
  - toggling mode after 2 strobes behaves identically
- ena=0 with strobes toggling → no state change. Assert rst_n=0 mid-batch → uo_out=0x00 and valid=0 immediately, before any clock edge.
- Build with STREAMING_MAJORITY_FILL_EN, DEPTH=5, five strobes → uio_out[7:4] reads 1, 2, 3, 4, 5 and uio_oe=0xF8. Build without it → uio_out[7:4]=0 and uio_oe=0x08.
